// File: rtl/ntsc_composite_line_generator.sv
// NTSC composite line generator: line timing FSM, colour sub-carrier phase,
// pixel fetch over valid/ready and registered composite sample output.
module ntsc_composite_line_generator #(
    parameter int OUT_W           = 8,
    parameter int PHASES          = 12,
    parameter int CLKS_PER_PIXEL  = 8,
    parameter int ACTIVE_PIXELS   = 256,
    parameter int SYNC_LEN        = 200,
    parameter int BREEZE_LEN      = 8,
    parameter int BURST_LEN       = 120,
    parameter int BACKPORCH_LEN   = 248,
    parameter int FRONTPORCH_LEN  = 104,
    parameter int LINE_PHASE_STEP = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pixel_valid,
    input  logic [5:0]       pixel_colour,
    input  logic [2:0]       emphasis,
    output logic             pixel_ready,
    output logic [OUT_W-1:0] video_out,
    output logic             line_start,
    output logic             underrun
);
    localparam int ACTIVE_LEN = ACTIVE_PIXELS * CLKS_PER_PIXEL;
    localparam int LINE_LEN   = SYNC_LEN + BREEZE_LEN + BURST_LEN + BACKPORCH_LEN
                              + ACTIVE_LEN + FRONTPORCH_LEN;
    localparam int CNT_W      = $clog2(LINE_LEN);
    localparam int PH_W       = $clog2(PHASES);
    localparam int SUB_W      = $clog2(CLKS_PER_PIXEL);
    localparam int PIX_W      = $clog2(ACTIVE_PIXELS + 1);
    localparam int HUE_STEP   = PHASES / 12;
    localparam int HALF       = PHASES / 2;
    localparam int STEP_MOD   = LINE_PHASE_STEP % PHASES;

    localparam logic [5:0] PIXEL_BLACK      = 6'h0F;
    localparam logic [7:0] LEVEL_SYNC       = 8'd0;
    localparam logic [7:0] LEVEL_BLACK      = 8'd47;
    localparam logic [7:0] LEVEL_BURST_HIGH = 8'd69;
    localparam logic [7:0] LEVEL_BURST_LOW  = 8'd23;

    typedef enum logic [2:0] {
        ST_SYNC, ST_BREEZE, ST_BURST, ST_BACKPORCH, ST_ACTIVE, ST_FRONTPORCH
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              state_last;
    logic [SUB_W-1:0]  sub_cnt_reg;
    logic [PIX_W-1:0]  pix_idx_reg;
    logic [PH_W-1:0]   phase_reg, phase_next;
    logic [PH_W-1:0]   line_phase_reg, line_phase_next;
    logic [PH_W:0]     lp_sum;
    logic [5:0]        pixel_reg;
    logic [2:0]        emph_reg;
    logic [15:0]       hue_win;
    logic [3:0]        hue;
    logic [1:0]        luma;
    logic              atten;
    logic [7:0]        level_hi, level_lo, sample8;
    logic [OUT_W-1:0]  sample_next;

    assign hue  = pixel_reg[3:0];
    assign luma = pixel_reg[5:4];

    function automatic logic [7:0] high_level(input logic [1:0] luma_v, input logic atten_v);
        logic [7:0] lv;
        case (luma_v)
            2'd0:    lv = atten_v ? 8'd76  : 8'd94;
            2'd1:    lv = atten_v ? 8'd103 : 8'd128;
            default: lv = atten_v ? 8'd136 : 8'd168;
        endcase
        return lv;
    endfunction

    function automatic logic [7:0] low_level(input logic [1:0] luma_v, input logic atten_v);
        logic [7:0] lv;
        case (luma_v)
            2'd0:    lv = atten_v ? 8'd29  : 8'd34;
            2'd1:    lv = atten_v ? 8'd39  : 8'd47;
            2'd2:    lv = atten_v ? 8'd68  : 8'd84;
            default: lv = atten_v ? 8'd110 : 8'd134;
        endcase
        return lv;
    endfunction

    // Line FSM next state, end-of-state detection and the pixel slot strobe
    always_comb begin
        state_next = state_reg;
        state_last = 1'b0;
        case (state_reg)
            ST_SYNC:       if (cnt_reg == CNT_W'(SYNC_LEN - 1))       begin state_last = 1'b1; state_next = ST_BREEZE;     end
            ST_BREEZE:     if (cnt_reg == CNT_W'(BREEZE_LEN - 1))     begin state_last = 1'b1; state_next = ST_BURST;      end
            ST_BURST:      if (cnt_reg == CNT_W'(BURST_LEN - 1))      begin state_last = 1'b1; state_next = ST_BACKPORCH;  end
            ST_BACKPORCH:  if (cnt_reg == CNT_W'(BACKPORCH_LEN - 1))  begin state_last = 1'b1; state_next = ST_ACTIVE;     end
            ST_ACTIVE:     if (cnt_reg == CNT_W'(ACTIVE_LEN - 1))     begin state_last = 1'b1; state_next = ST_FRONTPORCH; end
            ST_FRONTPORCH: if (cnt_reg == CNT_W'(FRONTPORCH_LEN - 1)) begin state_last = 1'b1; state_next = ST_SYNC;       end
            default:       begin state_last = 1'b1; state_next = ST_SYNC; end
        endcase
        cnt_next = state_last ? '0 : cnt_reg + CNT_W'(1);
        // One slot fetches the first pixel; every other slot pre-fetches the next one
        pixel_ready = (state_reg == ST_BACKPORCH && state_last) ||
                      (state_reg == ST_ACTIVE &&
                       sub_cnt_reg == SUB_W'(CLKS_PER_PIXEL - 1) &&
                       pix_idx_reg != PIX_W'(ACTIVE_PIXELS - 1));
    end

    // Sub-carrier phase: free-running, reloaded from the per-line phase on line wrap
    always_comb begin
        lp_sum = {1'b0, line_phase_reg} + (PH_W+1)'(STEP_MOD);
        if (lp_sum >= (PH_W+1)'(PHASES))
            lp_sum = lp_sum - (PH_W+1)'(PHASES);
        line_phase_next = line_phase_reg;
        phase_next      = (phase_reg == PH_W'(PHASES - 1)) ? '0 : phase_reg + PH_W'(1);
        if (state_reg == ST_FRONTPORCH && state_last) begin
            phase_next      = line_phase_reg;
            line_phase_next = lp_sum[PH_W-1:0];
        end
    end

    // Hue windows 1..12, each half a sub-carrier cycle wide and staggered by PHASES/12
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_hue_win
            if (gi >= 1 && gi <= 12) begin : g_live
                localparam int OFFSET = (gi - 1) * HUE_STEP;
                logic [PH_W:0] shifted;
                logic [PH_W:0] wrapped;
                assign shifted = {1'b0, phase_reg} + (PH_W+1)'(PHASES - OFFSET);
                assign wrapped = (shifted >= (PH_W+1)'(PHASES)) ? shifted - (PH_W+1)'(PHASES) : shifted;
                assign hue_win[gi] = (wrapped < (PH_W+1)'(HALF));
            end else begin : g_unused
                assign hue_win[gi] = 1'b0;
            end
        end
    endgenerate

    // Composite level for the current state, phase and pixel
    always_comb begin
        atten = (state_reg == ST_ACTIVE) && (hue <= 4'hD) &&
                ((emph_reg[2] && hue_win[8]) ||
                 (emph_reg[1] && hue_win[4]) ||
                 (emph_reg[0] && hue_win[12]));
        level_hi = high_level(luma, atten);
        level_lo = low_level(luma, atten);
        sample8  = LEVEL_BLACK;
        case (state_reg)
            ST_SYNC:  sample8 = LEVEL_SYNC;
            ST_BURST: sample8 = hue_win[8] ? LEVEL_BURST_HIGH : LEVEL_BURST_LOW;
            ST_ACTIVE: begin
                if (hue >= 4'hE)      sample8 = LEVEL_BLACK;
                else if (hue == 4'h0) sample8 = level_hi;
                else if (hue == 4'hD) sample8 = level_lo;
                else                  sample8 = hue_win[hue] ? level_hi : level_lo;
            end
            default:  sample8 = LEVEL_BLACK;
        endcase
        sample_next = OUT_W'(sample8) << (OUT_W - 8);
    end

    // Line FSM state and per-state clock counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_SYNC;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Clocks-within-pixel and pixel index counters, live only during ACTIVE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sub_cnt_reg <= '0;
            pix_idx_reg <= '0;
        end else if (state_reg == ST_ACTIVE && !state_last) begin
            if (sub_cnt_reg == SUB_W'(CLKS_PER_PIXEL - 1)) begin
                sub_cnt_reg <= '0;
                pix_idx_reg <= pix_idx_reg + PIX_W'(1);
            end else begin
                sub_cnt_reg <= sub_cnt_reg + SUB_W'(1);
            end
        end else begin
            sub_cnt_reg <= '0;
            pix_idx_reg <= '0;
        end
    end

    // Sub-carrier phase and per-line starting phase
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_reg      <= '0;
            line_phase_reg <= '0;
        end else begin
            phase_reg      <= phase_next;
            line_phase_reg <= line_phase_next;
        end
    end

    // Pixel/emphasis capture; missing pixels and the front porch show black
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_reg <= PIXEL_BLACK;
            emph_reg  <= '0;
        end else if (pixel_ready) begin
            if (pixel_valid) begin
                pixel_reg <= pixel_colour;
                emph_reg  <= emphasis;
            end else begin
                pixel_reg <= PIXEL_BLACK;
            end
        end else if (state_reg == ST_ACTIVE && state_last) begin
            pixel_reg <= PIXEL_BLACK;
        end
    end

    // Registered outputs: composite sample, line start and underrun pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            video_out  <= '0;
            line_start <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            video_out  <= sample_next;
            line_start <= (state_reg == ST_SYNC) && (cnt_reg == '0);
            underrun   <= pixel_ready && !pixel_valid;
        end
    end
endmodule

// File: tb/tb_ntsc_composite_line_generator.sv
// Randomised bench for the composite line generator against a line-position model.
module tb_ntsc_composite_line_generator;
    localparam int LINE_LEN = 2728;
    localparam int A0       = 576;   // first ACTIVE clock of a line
    localparam int A_END    = 2624;  // first FRONTPORCH clock of a line
    localparam int CPP      = 8;
    localparam int NPIX     = 256;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_valid = 1'b0;
    logic [5:0] pixel_colour = 6'h00;
    logic [2:0] emphasis = 3'b000;
    logic       pixel_ready;
    logic [7:0] video_out;
    logic       line_start;
    logic       underrun;

    int checks = 0;
    int errors = 0;
    int t = 0;

    int hi_tab[4]  = '{94, 128, 168, 168};
    int hia_tab[4] = '{76, 103, 136, 136};
    int lo_tab[4]  = '{34, 47, 84, 134};
    int loa_tab[4] = '{29, 39, 68, 110};

    // stimulus for the line being sent, and what each active pixel should show
    logic [5:0] line_col[NPIX];
    logic [2:0] line_em[NPIX];
    bit         line_ok[NPIX];
    logic [5:0] act_pix[NPIX];
    logic [2:0] act_em[NPIX];
    logic [2:0] cur_em;

    always #5 clock = ~clock;

    ntsc_composite_line_generator dut (
        .clock        (clock),
        .reset        (reset),
        .pixel_valid  (pixel_valid),
        .pixel_colour (pixel_colour),
        .emphasis     (emphasis),
        .pixel_ready  (pixel_ready),
        .video_out    (video_out),
        .line_start   (line_start),
        .underrun     (underrun)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, t, got, exp);
        end
    endtask

    function automatic bit win(input int ph, input int h);
        return ((((ph - (h - 1)) % 12) + 12) % 12) < 6;
    endfunction

    // line 0 starts at phase 0, line n>=1 starts at (n-1)*4 mod 12
    function automatic int start_phase(input int n);
        return (n == 0) ? 0 : ((n - 1) * 4) % 12;
    endfunction

    // pixel slot index at line clock k, or -1
    function automatic int slot_of(input int k);
        int d;
        d = k - (A0 - 1);
        if (d < 0 || (d % CPP) != 0 || (d / CPP) >= NPIX) return -1;
        return d / CPP;
    endfunction

    function automatic int model_sample(input int tt);
        int n, k, ph, p, hue, luma;
        logic [2:0] em;
        bit att;
        n  = tt / LINE_LEN;
        k  = tt % LINE_LEN;
        ph = (start_phase(n) + k) % 12;
        if (k < 200) return 0;
        if (k < 208) return 47;
        if (k < 328) return win(ph, 8) ? 69 : 23;
        if (k < A0 || k >= A_END) return 47;
        p    = (k - A0) / CPP;
        hue  = int'(act_pix[p][3:0]);
        luma = int'(act_pix[p][5:4]);
        em   = act_em[p];
        if (hue >= 14) return 47;
        att = (em[2] && win(ph, 8)) || (em[1] && win(ph, 4)) || (em[0] && win(ph, 12));
        if (hue == 0)  return att ? hia_tab[luma] : hi_tab[luma];
        if (hue == 13) return att ? loa_tab[luma] : lo_tab[luma];
        if (win(ph, hue)) return att ? hia_tab[luma] : hi_tab[luma];
        return att ? loa_tab[luma] : lo_tab[luma];
    endfunction

    task automatic fill_line(input int n);
        for (int j = 0; j < NPIX; j++) begin
            case (n)
                0: begin line_col[j] = 6'h20; line_em[j] = 3'b000; line_ok[j] = 1'b1; end
                1: begin line_col[j] = 6'h16; line_em[j] = 3'b000; line_ok[j] = 1'b1; end
                2: begin line_col[j] = 6'h16; line_em[j] = 3'b100; line_ok[j] = 1'b1; end
                3: begin
                    line_col[j] = 6'($urandom_range(0, 63));
                    line_em[j]  = 3'($urandom_range(0, 7));
                    line_ok[j]  = (j != 10);
                end
                default: begin
                    line_col[j] = 6'($urandom_range(0, 63));
                    line_em[j]  = 3'($urandom_range(0, 7));
                    line_ok[j]  = ($urandom_range(0, 9) != 0);
                end
            endcase
        end
    endtask

    // drive inputs for cycle tt: real data on slots, noise elsewhere
    task automatic drive(input int tt);
        int k, j;
        k = tt % LINE_LEN;
        if (k == 0) fill_line(tt / LINE_LEN);
        j = slot_of(k);
        if (j >= 0) begin
            pixel_colour = line_col[j];
            emphasis     = line_em[j];
            pixel_valid  = line_ok[j];
            act_pix[j]   = line_ok[j] ? line_col[j] : 6'h0F;
            act_em[j]    = line_ok[j] ? line_em[j] : cur_em;
            if (line_ok[j]) cur_em = line_em[j];
        end else begin
            pixel_colour = 6'($urandom_range(0, 63));
            emphasis     = 3'($urandom_range(0, 7));
            pixel_valid  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_cycles(input int ncycles);
        int jp;
        for (int i = 0; i < ncycles; i++) begin
            @(posedge clock);
            #1;
            t++;
            jp = slot_of((t - 1) % LINE_LEN);
            check("video_out", int'(video_out), model_sample(t - 1));
            check("line_start", int'(line_start), int'(((t - 1) % LINE_LEN) == 0));
            check("underrun", int'(underrun), int'(jp >= 0 && !line_ok[jp]));
            check("pixel_ready", int'(pixel_ready), int'(slot_of(t % LINE_LEN) >= 0));
            drive(t);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_video_out"}, int'(video_out), 0);
        check({tag, "_pixel_ready"}, int'(pixel_ready), 0);
        check({tag, "_line_start"}, int'(line_start), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset  = 1'b0;
        t      = 0;
        cur_em = 3'b000;
        drive(0);
    endtask

    initial begin
        cur_em = 3'b000;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        release_reset();
        run_cycles(5 * LINE_LEN + 10);
        // move into the ACTIVE span of line 5, then reset mid-line
        run_cycles(1000);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midline_reset");
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("held_reset");
        release_reset();
        run_cycles(LINE_LEN + 700);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
